tick_sequencer: RTL

TICK_SEQUENCER -- requirements
Module: tick_sequencer

---
 rtl/tick_sequencer_if.sv | 49 ++++
 rtl/tick_sequencer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/tick_sequencer_if.sv
// ---------------------------------------------------------------------------
// tick_sequencer_if
//   Control and status bundle for tick_sequencer.
//
//   Parameters
//     N : width of period and count
//     R : width of repeats and rep_done
//
//   Signals (direction given from the sequencer's point of view)
//     start    in   begin a sequence; only sampled while idle
//     abort    in   terminate a running sequence
//     period   in   tick-counter modulus P
//     repeats  in   ticks per sequence K
//     busy     out  sequence running
//     count    out  current tick-counter value
//     tick     out  counter is at P-1 while running
//     rep_done out  ticks completed in the current sequence
//     done     out  one-cycle pulse on normal completion
//     err      out  one-cycle pulse after a rejected start
//
//   Modports
//     slave  : the sequencer
//     master : whoever drives start/abort and consumes the status
// ---------------------------------------------------------------------------
interface tick_sequencer_if #(
    parameter int N = 8,
    parameter int R = 8
);
    logic         start;
    logic         abort;
    logic [N-1:0] period;
    logic [R-1:0] repeats;
    logic         busy;
    logic [N-1:0] count;
    logic         tick;
    logic [R-1:0] rep_done;
    logic         done;
    logic         err;

    modport slave (
        input  start, abort, period, repeats,
        output busy, count, tick, rep_done, done, err
    );

    modport master (
        output start, abort, period, repeats,
        input  busy, count, tick, rep_done, done, err
    );
endinterface

// File: rtl/tick_sequencer.sv
// ---------------------------------------------------------------------------
// tick_sequencer
//   On an accepted start, latches a period P and a repeat count K, then runs
//   a modulo-P counter that raises tick once per period until K ticks have
//   occurred. A run lasts exactly P*K cycles, followed by a single DONE cycle
//   that pulses done. A start with P==0 or K==0 is refused and pulses err on
//   the following cycle. abort ends a run early without a done pulse.
//
//   Ports
//     clk   : clock, all state changes on the rising edge
//     reset : synchronous, active-low
//     bus   : tick_sequencer_if.slave (start/abort/period/repeats in,
//             busy/count/tick/rep_done/done/err out)
// ---------------------------------------------------------------------------
module tick_sequencer #(
    parameter int N = 8,
    parameter int R = 8
) (
    input  logic            clk,
    input  logic            reset,
    tick_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state,     state_nx;
    logic [N-1:0] count,     count_nx;
    logic [N-1:0] period_q,  period_nx;
    logic [R-1:0] rep_done,  rep_nx;
    logic [R-1:0] repeats_q, repeats_nx;
    logic         err_q,     err_nx;
    logic         tick;
    logic         last_tick;

    // Both compares stay in their own widths, so P-1 and K-1 never widen or
    // overflow. Latched values are nonzero whenever the state is RUN.
    assign tick      = (state == RUN) && (count == period_q - N'(1));
    assign last_tick = (rep_done == repeats_q - R'(1));

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        rep_nx     = rep_done;
        period_nx  = period_q;
        repeats_nx = repeats_q;
        err_nx     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    if ((bus.period != '0) && (bus.repeats != '0)) begin
                        period_nx  = bus.period;
                        repeats_nx = bus.repeats;
                        count_nx   = '0;
                        rep_nx     = '0;
                        state_nx   = RUN;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end

            RUN: begin
                // abort wins over a coincident final tick: tick is still
                // visible this cycle, but rep_done holds and done is skipped.
                if (bus.abort) begin
                    count_nx = '0;
                    state_nx = IDLE;
                end else if (tick) begin
                    count_nx = '0;
                    rep_nx   = rep_done + R'(1);
                    if (last_tick) begin
                        state_nx = DONE;
                    end
                end else begin
                    count_nx = count + N'(1);
                end
            end

            DONE: begin
                state_nx = IDLE;
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count     <= '0;
            rep_done  <= '0;
            period_q  <= '0;
            repeats_q <= '0;
            err_q     <= 1'b0;
        end else begin
            count     <= count_nx;
            rep_done  <= rep_nx;
            period_q  <= period_nx;
            repeats_q <= repeats_nx;
            err_q     <= err_nx;
        end
    end

    assign bus.busy     = (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.tick     = tick;
    assign bus.count    = count;
    assign bus.rep_done = rep_done;
    assign bus.err      = err_q;

endmodule
